// File: rtl/prio_pkg.sv
// Constants shared by the priority encoder/arbiter and its search sub-module.
package prio_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   BUSY_W     = 8;
    localparam logic [BUSY_W-1:0] BUSY_MAX = '1;
endpackage

// File: rtl/prio_pick.sv
// Combinational priority search: first set bit of vec_i scanning downward from start_i (wrapping).
// Fixed mode ignores start_i and starts at N-1, so the highest set index wins.
module prio_pick
    import prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    input  logic         mode_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        int base;
        int p;
        logic [W-1:0] pw;
        idx_o   = '0;
        found_o = 1'b0;
        base    = (mode_i == MODE_RR) ? int'(start_i) : N - 1;
        // Scan farthest-first so the position closest to base overwrites last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            p = base - k;
            if (p < 0) p = p + N;
            pw = W'(p);
            if (vec_i[pw]) begin
                idx_o   = pw;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_arb.sv
// Priority encoder / round-robin arbiter with a single registered output slot; latency 1 request-to-winner.
// Backpressure: slot holds while out_valid && !out_ready; requests arriving then are dropped and counted in busy_cnt.
module prio_enc_arb
    import prio_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int RR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_idx,
    output logic [N-1:0]      out_onehot,
    output logic [BUSY_W-1:0] busy_cnt
);

    localparam logic         MODE     = (RR != 0) ? MODE_RR : MODE_FIXED;
    localparam logic [W-1:0] PTR_INIT = W'(N - 1);
    localparam logic [N-1:0] ONE      = N'(1);

    logic              valid_q, valid_d;
    logic [W-1:0]      idx_q, idx_d;
    logic [N-1:0]      hot_q, hot_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    logic [W-1:0]      ptr_q, ptr_d;

    logic [W-1:0] pick_idx;
    logic         pick_found;
    logic         slot_free;
    logic         capture;
    logic         blocked;

    prio_pick #(.N(N), .W(W)) u_pick (
        .vec_i   (req),
        .start_i (ptr_q),
        .mode_i  (MODE),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        slot_free = !valid_q || out_ready;
        capture   = en && pick_found && slot_free;
        blocked   = en && pick_found && !slot_free;
        valid_d   = valid_q;
        idx_d     = idx_q;
        hot_d     = hot_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        if (capture) begin
            valid_d = 1'b1;
            idx_d   = pick_idx;
            hot_d   = ONE << pick_idx;
            // Pointer moves just below the winner so the winner becomes lowest priority next time.
            if (MODE == MODE_RR) ptr_d = (pick_idx == '0) ? PTR_INIT : pick_idx - W'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            idx_d   = '0;
            hot_d   = '0;
        end
        if (blocked && busy_q != BUSY_MAX) busy_d = busy_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            hot_q   <= '0;
            busy_q  <= '0;
            ptr_q   <= PTR_INIT;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            hot_q   <= hot_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = hot_q;
    assign busy_cnt   = busy_q;

endmodule
